// File: rtl/mips_defs_pkg.sv
// Definitions shared by the fetch unit and Ctrl_Unit: opcodes, fetch states
// and the bit positions of the instruction fields.
package mips_defs_pkg;

   localparam logic [5:0] OP_HALT = 6'd0;
   localparam logic [5:0] OP_ALU  = 6'd1;
   localparam logic [5:0] OP_LW   = 6'd2;
   localparam logic [5:0] OP_SW   = 6'd3;
   localparam logic [5:0] OP_BEQ  = 6'd4;
   localparam logic [5:0] OP_JUMP = 6'd5;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   typedef enum logic [1:0] {
      FS_IDLE  = ST_IDLE,
      FS_FETCH = ST_FETCH,
      FS_ISSUE = ST_ISSUE,
      FS_HALT  = ST_HALT
   } fetch_state_e;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;
   localparam int TGT_MSB = 25;
   localparam int TGT_LSB = 0;

   // Opcodes above JUMP are undefined and execute as NOPs.
   function automatic logic is_illegal(input logic [5:0] op);
      return op > OP_JUMP;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory, issue and control-unit signals.
// master = fetch unit side, slave = memory / control unit / datapath side.
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [5:0]  i_code;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm16;
   logic        exec_done;
   logic        pc_sel;
   logic [31:0] pc;
   logic        halted;
   logic        illegal;

   modport master (
      output imem_req, imem_addr, instr_valid, i_code, rs, rt, rd, imm16,
             pc, halted, illegal,
      input  imem_ready, imem_rdata, exec_done, pc_sel
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, i_code, rs, rt, rd, imm16,
             pc, halted, illegal,
      output imem_ready, imem_rdata, exec_done, pc_sel
   );
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Next-PC selection: sequential, BEQ-relative or JUMP-absolute.
// All arithmetic wraps modulo 2^32.
module next_pc_calc
   import mips_defs_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] ir_i,
   input  logic        pc_sel_i,
   output logic [31:0] next_pc_o
);

   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic [31:0] branch_target;

   assign pc_plus4      = pc_i + 32'd4;
   assign jump_target   = {pc_plus4[31:28], ir_i[TGT_MSB:TGT_LSB], 2'b00};
   assign branch_target = pc_plus4 + {{14{ir_i[IMM_MSB]}}, ir_i[IMM_MSB:IMM_LSB], 2'b00};

   // Any non-JUMP opcode with pc_sel set is treated as a BEQ.
   always_comb begin
      next_pc_o = pc_plus4;
      if (pc_sel_i) begin
         if (ir_i[OPC_MSB:OPC_LSB] == OP_JUMP) begin
            next_pc_o = jump_target;
         end else begin
            next_pc_o = branch_target;
         end
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: owns the PC, fetches over req/ready, issues the
// instruction register to the control unit and retires on exec_done.
module instr_fetch_unit
   import mips_defs_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_fetch_unit_if.master ifu
);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic        illegal_q, illegal_d;
   logic [31:0] next_pc;

   next_pc_calc u_next_pc (
      .pc_i      (pc_q),
      .ir_i      (ir_q),
      .pc_sel_i  (ifu.pc_sel),
      .next_pc_o (next_pc)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      illegal_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (ifu.imem_ready) begin
               ir_d    = ifu.imem_rdata;
               state_d = (ifu.imem_rdata[OPC_MSB:OPC_LSB] == OP_HALT) ? ST_HALT : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ifu.exec_done) begin
               pc_d      = next_pc;
               illegal_d = is_illegal(ir_q[OPC_MSB:OPC_LSB]);
               state_d   = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         ir_q      <= 32'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
      end
   end

   // Fields follow IR; they hold their last value outside ISSUE.
   assign ifu.imem_req    = (state_q == ST_FETCH);
   assign ifu.imem_addr   = pc_q;
   assign ifu.instr_valid = (state_q == ST_ISSUE);
   assign ifu.i_code      = ir_q[OPC_MSB:OPC_LSB];
   assign ifu.rs          = ir_q[RS_MSB:RS_LSB];
   assign ifu.rt          = ir_q[RT_MSB:RT_LSB];
   assign ifu.rd          = ir_q[RD_MSB:RD_LSB];
   assign ifu.imm16       = ir_q[IMM_MSB:IMM_LSB];
   assign ifu.pc          = pc_q;
   assign ifu.halted      = (state_q == ST_HALT);
   assign ifu.illegal     = illegal_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit with a next-PC
// reference model built from plain address arithmetic.
module tb_instr_fetch_unit;
   import mips_defs_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] W_ALU    = 32'h0400_0000;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   logic [31:0] exp_pc;

   instr_fetch_unit_if bus();

   instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ifu   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference next-PC: sequential, absolute jump within the 256MB region, or
   // word-scaled signed branch offset from pc+4.
   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w, input bit sel);
      logic [31:0] seq;
      logic [15:0] imm;
      int          off;
      seq = pc + 32'd4;
      imm = w[15:0];
      off = $signed(imm);
      if (!sel) return seq;
      if ((w >> 26) == 32'd5) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      return seq + 32'(off * 4);
   endfunction

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (bus.imem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, bus.imem_req}, 32'd1);
   endtask

   task automatic fetch_one(input logic [31:0] w, input bit sel, input int stall, input int ewait);
      logic [31:0] exp_next;
      bit          ill;
      wait_req("req_rise");
      chk("fetch_addr", bus.imem_addr, exp_pc);
      chk("fetch_valid", {31'd0, bus.instr_valid}, 32'd0);
      for (int i = 0; i < stall; i++) begin
         bus.imem_ready = 1'b0;
         bus.pc_sel     = ~sel;
         tick();
         chk("stall_req", {31'd0, bus.imem_req}, 32'd1);
         chk("stall_addr", bus.imem_addr, exp_pc);
         chk("stall_valid", {31'd0, bus.instr_valid}, 32'd0);
      end
      bus.imem_ready = 1'b1;
      bus.imem_rdata = w;
      bus.pc_sel     = sel;
      bus.exec_done  = 1'b0;
      tick();
      bus.imem_ready = 1'b0;
      bus.imem_rdata = $urandom;
      if ((w >> 26) == 32'd0) begin
         chk("halt_flag", {31'd0, bus.halted}, 32'd1);
         chk("halt_req", {31'd0, bus.imem_req}, 32'd0);
         chk("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
         chk("halt_pc", bus.pc, exp_pc);
         return;
      end
      chk("issue_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("issue_req", {31'd0, bus.imem_req}, 32'd0);
      chk("issue_halted", {31'd0, bus.halted}, 32'd0);
      chk("i_code", {26'd0, bus.i_code}, w >> 26);
      chk("rs", {27'd0, bus.rs}, {27'd0, w[25:21]});
      chk("rt", {27'd0, bus.rt}, {27'd0, w[20:16]});
      chk("rd", {27'd0, bus.rd}, {27'd0, w[15:11]});
      chk("imm16", {16'd0, bus.imm16}, {16'd0, w[15:0]});
      for (int i = 0; i < ewait; i++) begin
         tick();
         chk("wait_valid", {31'd0, bus.instr_valid}, 32'd1);
         chk("wait_icode", {26'd0, bus.i_code}, w >> 26);
         chk("wait_pc", bus.pc, exp_pc);
      end
      bus.exec_done = 1'b1;
      tick();
      bus.exec_done = 1'b0;
      exp_next = model_next(exp_pc, w, sel);
      ill      = (w >> 26) >= 32'd6;
      chk("illegal_pulse", {31'd0, bus.illegal}, {31'd0, ill});
      chk("next_addr", bus.imem_addr, exp_next);
      chk("next_pc", bus.pc, exp_next);
      exp_pc = exp_next;
      tick();
      chk("illegal_clear", {31'd0, bus.illegal}, 32'd0);
      chk("hold_req", {31'd0, bus.imem_req}, 32'd1);
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      bus.imem_ready = 1'b0;
      bus.exec_done  = 1'b0;
      bus.pc_sel     = 1'b0;
      tick();
      rst_n  = 1'b1;
      exp_pc = RESET_PC;
   endtask

   initial begin
      logic [31:0] r;
      logic [5:0]  op;
      rst_n          = 1'b0;
      bus.imem_ready = 1'b0;
      bus.imem_rdata = 32'd0;
      bus.exec_done  = 1'b0;
      bus.pc_sel     = 1'b0;
      tick();
      tick();
      chk("rst_pc", bus.pc, RESET_PC);
      chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("rst_halted", {31'd0, bus.halted}, 32'd0);
      chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
      chk("rst_fields", {bus.i_code, bus.rs, bus.rt, bus.rd, bus.imm16}, 32'd0);

      // Back-to-back ALU words with handshakes tied high.
      rst_n          = 1'b1;
      bus.imem_ready = 1'b1;
      bus.exec_done  = 1'b1;
      bus.imem_rdata = W_ALU;
      wait_req("first_req");
      for (int k = 0; k < 3; k++) begin
         chk("alu_addr", bus.imem_addr, 32'(4 * k));
         chk("alu_valid_lo", {31'd0, bus.instr_valid}, 32'd0);
         tick();
         chk("alu_valid_hi", {31'd0, bus.instr_valid}, 32'd1);
         chk("alu_icode", {26'd0, bus.i_code}, 32'd1);
         chk("alu_req_lo", {31'd0, bus.imem_req}, 32'd0);
         tick();
      end
      bus.imem_ready = 1'b0;
      bus.exec_done  = 1'b0;
      exp_pc = 32'h0000_000C;

      // Branch and jump targets.
      fetch_one(32'h1400_0004, 1'b1, 0, 0);
      fetch_one(32'h1000_0003, 1'b1, 0, 1);
      chk("beq_taken", bus.imem_addr, 32'h0000_0020);
      fetch_one(32'h1400_0004, 1'b1, 0, 0);
      fetch_one(32'h1000_0003, 1'b0, 0, 0);
      chk("beq_not_taken", bus.imem_addr, 32'h0000_0014);

      // Stalled fetch of an illegal opcode.
      fetch_one(32'hFC00_0000, 1'b0, 3, 0);
      chk("illegal_adv", bus.imem_addr, 32'h0000_0018);

      for (int n = 0; n < 30; n++) begin
         r  = $urandom;
         op = 6'($urandom_range(1, 63));
         fetch_one({op, r[25:0]}, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      // HALT at 0x8 is sticky until reset.
      do_reset();
      fetch_one(W_ALU, 1'b0, 0, 0);
      fetch_one(W_ALU, 1'b0, 0, 0);
      fetch_one(32'h0000_0000, 1'b0, 0, 0);
      bus.imem_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("halt_sticky", {31'd0, bus.halted}, 32'd1);
         chk("halt_noreq", {31'd0, bus.imem_req}, 32'd0);
         chk("halt_pc_hold", bus.pc, 32'h0000_0008);
      end
      do_reset();
      chk("unhalt_pc", bus.pc, RESET_PC);
      chk("unhalt_flag", {31'd0, bus.halted}, 32'd0);

      // Backward branch wraps below zero, sequential step wraps back to zero.
      fetch_one(32'h1000_FFFE, 1'b1, 0, 0);
      chk("wrap_down", bus.imem_addr, 32'hFFFF_FFFC);
      fetch_one(W_ALU, 1'b0, 0, 0);
      chk("wrap_up", bus.imem_addr, 32'h0000_0000);

      // Walk into the 0x1000_0000 region with maximal forward branches.
      wait_req("far_start");
      bus.imem_ready = 1'b1;
      bus.exec_done  = 1'b1;
      bus.pc_sel     = 1'b1;
      bus.imem_rdata = 32'h1000_7FFF;
      for (int i = 0; i < 2048; i++) begin
         tick();
         tick();
         exp_pc = model_next(exp_pc, 32'h1000_7FFF, 1'b1);
      end
      bus.imem_ready = 1'b0;
      bus.exec_done  = 1'b0;
      bus.pc_sel     = 1'b0;
      chk("far_addr", bus.imem_addr, exp_pc);
      fetch_one(32'h1000_0001, 1'b1, 0, 0);
      chk("far_beq", bus.imem_addr, 32'h1000_0008);
      fetch_one(32'h1400_0040, 1'b1, 0, 0);
      chk("far_jump", bus.imem_addr, 32'h1000_0100);

      // Reset during ISSUE discards the PC update.
      bus.imem_ready = 1'b1;
      bus.imem_rdata = W_ALU;
      tick();
      bus.imem_ready = 1'b0;
      chk("pre_rst_valid", {31'd0, bus.instr_valid}, 32'd1);
      bus.exec_done = 1'b1;
      rst_n = 1'b0;
      tick();
      chk("issue_rst_pc", bus.pc, RESET_PC);
      chk("issue_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("issue_rst_illegal", {31'd0, bus.illegal}, 32'd0);
      chk("issue_rst_icode", {26'd0, bus.i_code}, 32'd0);
      rst_n = 1'b1;
      bus.exec_done = 1'b0;
      exp_pc = RESET_PC;
      wait_req("post_rst_req");

      // Reset during FETCH discards a concurrent ready.
      bus.imem_ready = 1'b1;
      bus.imem_rdata = W_ALU;
      rst_n = 1'b0;
      tick();
      chk("fetch_rst_req", {31'd0, bus.imem_req}, 32'd0);
      chk("fetch_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("fetch_rst_icode", {26'd0, bus.i_code}, 32'd0);
      rst_n = 1'b1;
      bus.imem_ready = 1'b0;
      fetch_one(W_ALU, 1'b0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
